// File: rtl/imem_arbiter.sv
// Two-core instruction-fetch arbiter in front of a single synchronous ROM.
// Alternating priority on contention, one-cycle response routing with per-core flush kill, saturating stall counters.
module imem_arbiter #(
  parameter int AW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c0_req_valid,
  input  logic [AW-1:0] c0_req_addr,
  output logic          c0_req_ready,
  input  logic          c0_flush,
  output logic          c0_rsp_valid,
  output logic [31:0]   c0_rsp_instr,
  output logic [CW-1:0] c0_stall_cnt,
  input  logic          c1_req_valid,
  input  logic [AW-1:0] c1_req_addr,
  output logic          c1_req_ready,
  input  logic          c1_flush,
  output logic          c1_rsp_valid,
  output logic [31:0]   c1_rsp_instr,
  output logic [CW-1:0] c1_stall_cnt,
  output logic          mem_en,
  output logic [AW-1:0] mem_pc,
  input  logic [31:0]   mem_instr
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic          w_gnt0;
  logic          w_gnt1;
  logic [AW-1:0] w_mem_pc;
  logic          r_prio;
  logic          r_infl_v;
  logic          r_infl_id;
  logic [CW-1:0] r_stall0;
  logic [CW-1:0] r_stall1;

  // Grant: pointer breaks ties, a lone requester always wins, reset blocks all grants.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst_n) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end else if (c0_req_valid && c1_req_valid) begin
      w_gnt0 = ~r_prio;
      w_gnt1 = r_prio;
    end else begin
      w_gnt0 = c0_req_valid;
      w_gnt1 = c1_req_valid;
    end
  end

  // ROM address mux: pass the winner's address through untouched.
  always_comb begin
    w_mem_pc = '0;
    case ({w_gnt1, w_gnt0})
      2'b01:   w_mem_pc = c0_req_addr;
      2'b10:   w_mem_pc = c1_req_addr;
      default: w_mem_pc = '0;
    endcase
  end

  // Priority pointer and in-flight tag for the response one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio    <= 1'b0;
      r_infl_v  <= 1'b0;
      r_infl_id <= 1'b0;
    end else begin
      if (w_gnt0) begin
        r_prio <= 1'b1;
      end else if (w_gnt1) begin
        r_prio <= 1'b0;
      end else begin
        r_prio <= r_prio;
      end
      r_infl_v  <= w_gnt0 | w_gnt1;
      r_infl_id <= w_gnt1;
    end
  end

  // Stall counters saturate rather than wrap so long starvation stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall0 <= '0;
      r_stall1 <= '0;
    end else begin
      if (c0_req_valid && !w_gnt0 && (r_stall0 != CNT_MAX)) begin
        r_stall0 <= r_stall0 + CNT_ONE;
      end else begin
        r_stall0 <= r_stall0;
      end
      if (c1_req_valid && !w_gnt1 && (r_stall1 != CNT_MAX)) begin
        r_stall1 <= r_stall1 + CNT_ONE;
      end else begin
        r_stall1 <= r_stall1;
      end
    end
  end

  assign c0_req_ready = w_gnt0;
  assign c1_req_ready = w_gnt1;
  assign mem_en       = w_gnt0 | w_gnt1;
  assign mem_pc       = w_mem_pc;

  // A flush only kills the response arriving in the same cycle; a new grant that cycle survives.
  assign c0_rsp_valid = rst_n & r_infl_v & ~r_infl_id & ~c0_flush;
  assign c1_rsp_valid = rst_n & r_infl_v &  r_infl_id & ~c1_flush;
  assign c0_rsp_instr = mem_instr;
  assign c1_rsp_instr = mem_instr;
  assign c0_stall_cnt = r_stall0;
  assign c1_stall_cnt = r_stall1;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: rule-level model compared every cycle, plus hand-computed literal checks.
module tb_imem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        c0_req_valid, c1_req_valid;
  logic [31:0] c0_req_addr, c1_req_addr;
  logic        c0_flush, c1_flush;
  logic        c0_req_ready, c1_req_ready;
  logic        c0_rsp_valid, c1_rsp_valid;
  logic [31:0] c0_rsp_instr, c1_rsp_instr;
  logic [15:0] c0_stall_cnt, c1_stall_cnt;
  logic        mem_en;
  logic [31:0] mem_pc;
  logic [31:0] mem_instr;

  logic        s_c0_req_ready, s_c1_req_ready, s_c0_rsp_valid, s_c1_rsp_valid, s_mem_en;
  logic [31:0] s_c0_rsp_instr, s_c1_rsp_instr, s_mem_pc;
  logic [1:0]  s_c0_stall_cnt, s_c1_stall_cnt;
  logic [31:0] zero_instr;

  logic [31:0] rom [0:63];
  int n_checks;
  int n_errors;

  int          m_prio;
  int          m_pend;
  logic [31:0] m_pend_addr;
  int          m_stall0;
  int          m_stall1;

  imem_arbiter #(.AW(32), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_ready(c0_req_ready),
    .c0_flush(c0_flush), .c0_rsp_valid(c0_rsp_valid), .c0_rsp_instr(c0_rsp_instr),
    .c0_stall_cnt(c0_stall_cnt),
    .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr), .c1_req_ready(c1_req_ready),
    .c1_flush(c1_flush), .c1_rsp_valid(c1_rsp_valid), .c1_rsp_instr(c1_rsp_instr),
    .c1_stall_cnt(c1_stall_cnt),
    .mem_en(mem_en), .mem_pc(mem_pc), .mem_instr(mem_instr)
  );

  imem_arbiter #(.AW(32), .CW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_ready(s_c0_req_ready),
    .c0_flush(c0_flush), .c0_rsp_valid(s_c0_rsp_valid), .c0_rsp_instr(s_c0_rsp_instr),
    .c0_stall_cnt(s_c0_stall_cnt),
    .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr), .c1_req_ready(s_c1_req_ready),
    .c1_flush(c1_flush), .c1_rsp_valid(s_c1_rsp_valid), .c1_rsp_instr(s_c1_rsp_instr),
    .c1_stall_cnt(s_c1_stall_cnt),
    .mem_en(s_mem_en), .mem_pc(s_mem_pc), .mem_instr(zero_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: word appears one cycle after the enable.
  always @(posedge clk) begin
    if (mem_en) mem_instr <= rom[mem_pc[7:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sat(input int x, input int mx);
    return (x > mx) ? mx : x;
  endfunction

  // Per-cycle model: grant rule, one-cycle response with flush kill, saturating stall counts.
  initial begin : cmp
    int g;
    logic [31:0] e_pc;
    logic e_rv0, e_rv1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_prio = 0; m_pend = -1; m_stall0 = 0; m_stall1 = 0;
      end
      if (!rst_n)                          g = -1;
      else if (c0_req_valid && c1_req_valid) g = m_prio;
      else if (c0_req_valid)               g = 0;
      else if (c1_req_valid)               g = 1;
      else                                 g = -1;
      e_pc  = (g == 0) ? c0_req_addr : (g == 1) ? c1_req_addr : 32'h0;
      e_rv0 = rst_n && (m_pend == 0) && !c0_flush;
      e_rv1 = rst_n && (m_pend == 1) && !c1_flush;
      chk("ready0", {31'd0, c0_req_ready}, {31'd0, g == 0});
      chk("ready1", {31'd0, c1_req_ready}, {31'd0, g == 1});
      chk("mem_en", {31'd0, mem_en}, {31'd0, g >= 0});
      chk("mem_pc", mem_pc, e_pc);
      chk("rsp_valid0", {31'd0, c0_rsp_valid}, {31'd0, e_rv0});
      chk("rsp_valid1", {31'd0, c1_rsp_valid}, {31'd0, e_rv1});
      if (e_rv0) chk("rsp_instr0", c0_rsp_instr, rom[m_pend_addr[7:2]]);
      if (e_rv1) chk("rsp_instr1", c1_rsp_instr, rom[m_pend_addr[7:2]]);
      chk("stall0", {16'd0, c0_stall_cnt}, sat(m_stall0, 65535));
      chk("stall1", {16'd0, c1_stall_cnt}, sat(m_stall1, 65535));
      chk("sat_stall0", {30'd0, s_c0_stall_cnt}, sat(m_stall0, 3));
      chk("sat_stall1", {30'd0, s_c1_stall_cnt}, sat(m_stall1, 3));
      if (g == 0) m_prio = 1;
      else if (g == 1) m_prio = 0;
      if (rst_n) begin
        if (c0_req_valid && g != 0) m_stall0++;
        if (c1_req_valid && g != 1) m_stall1++;
      end
      m_pend      = g;
      m_pend_addr = e_pc;
    end
  end

  task automatic drive(input logic v0, input logic [31:0] a0, input logic v1, input logic [31:0] a1,
                       input logic f0, input logic f1);
    @(posedge clk); #1;
    c0_req_valid = v0; c0_req_addr = a0; c1_req_valid = v1; c1_req_addr = a1;
    c0_flush = f0; c1_flush = f1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 | i;
    rom[0] = 32'h0010_0313;
    rom[1] = 32'h0020_0393;
    rom[7] = 32'h0020_0613;
    n_checks = 0; n_errors = 0;
    m_prio = 0; m_pend = -1; m_pend_addr = 32'h0; m_stall0 = 0; m_stall1 = 0;
    zero_instr = 32'h0;
    mem_instr = 32'h0;
    rst_n = 1'b1;
    c0_req_valid = 1'b0; c0_req_addr = 32'h0; c1_req_valid = 1'b0; c1_req_addr = 32'h0;
    c0_flush = 1'b0; c1_flush = 1'b0;
    #1 rst_n = 1'b0;
    c0_req_valid = 1'b1; c0_req_addr = 32'h40; c1_req_valid = 1'b1; c1_req_addr = 32'h44;
    settle();
    chk("lit_rst_ready0", {31'd0, c0_req_ready}, 32'd0);
    chk("lit_rst_ready1", {31'd0, c1_req_ready}, 32'd0);
    chk("lit_rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("lit_rst_mem_pc", mem_pc, 32'd0);
    chk("lit_rst_stall1", {16'd0, c1_stall_cnt}, 32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    c0_req_valid = 1'b0; c1_req_valid = 1'b0;

    // core0 alone, two back-to-back fetches
    drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("lit_c0_ready_a", {31'd0, c0_req_ready}, 32'd1);
    drive(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("lit_c0_ready_b", {31'd0, c0_req_ready}, 32'd1);
    chk("lit_c0_rsp_a", {31'd0, c0_rsp_valid}, 32'd1);
    chk("lit_c0_instr_a", c0_rsp_instr, 32'h0010_0313);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("lit_c0_rsp_b", {31'd0, c0_rsp_valid}, 32'd1);
    chk("lit_c0_instr_b", c0_rsp_instr, 32'h0020_0393);

    // both valid continuously from reset: grants alternate starting with core0
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    c0_req_valid = 1'b1; c0_req_addr = 32'h0; c1_req_valid = 1'b1; c1_req_addr = 32'h40;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("lit_alt_ready0", {31'd0, c0_req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("lit_alt_ready1", {31'd0, c1_req_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i < 5) @(posedge clk);
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("lit_alt_stall0", {16'd0, c0_stall_cnt}, 32'd3);
    chk("lit_alt_stall1", {16'd0, c1_stall_cnt}, 32'd3);

    // core1 flush kills its pending response but not the fetch issued with the flush
    drive(1'b0, 32'h0, 1'b1, 32'h14, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 32'h1C, 1'b0, 1'b1);
    settle();
    chk("lit_flush_kill", {31'd0, c1_rsp_valid}, 32'd0);
    chk("lit_flush_ready", {31'd0, c1_req_ready}, 32'd1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("lit_flush_new_rsp", {31'd0, c1_rsp_valid}, 32'd1);
    chk("lit_flush_new_instr", c1_rsp_instr, 32'h0020_0613);

    // a flush from the other core leaves core0's response alone
    drive(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    settle();
    chk("lit_xflush_rsp0", {31'd0, c0_rsp_valid}, 32'd1);

    // reset right after a grant discards the in-flight fetch
    drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0; c0_req_valid = 1'b0;
    settle();
    chk("lit_rstmid_rsp0", {31'd0, c0_rsp_valid}, 32'd0);
    chk("lit_rstmid_stall0", {16'd0, c0_stall_cnt}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    settle();
    chk("lit_rstpost_rsp0", {31'd0, c0_rsp_valid}, 32'd0);

    // sustained contention: prio restarts at core0, narrow counters saturate
    drive(1'b1, 32'h20, 1'b1, 32'h30, 1'b0, 1'b0);
    settle();
    chk("lit_postrst_prio", {31'd0, c0_req_ready}, 32'd1);
    repeat (13) @(posedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    settle();
    chk("lit_sat_stall1", {30'd0, s_c1_stall_cnt}, 32'd3);
    chk("lit_wide_stall1", {16'd0, c1_stall_cnt}, 32'd7);

    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
